sr_latch_bank: RTL

SR_LATCH_BANK -- requirements
Module: sr_latch_bank

---
 rtl/sr_bank_pkg.sv | 45 ++++
 rtl/sr_cell.sv | 69 ++++++
 rtl/sr_latch_bank.sv | 46 ++++
 3 files changed

// File: rtl/sr_bank_pkg.sv
// Shared constants for the set/reset latch bank: conflict-policy encodings,
// default sizes and the per-channel next-state rule.
package sr_bank_pkg;

    localparam int DEFAULT_N  = 8;
    localparam int DEFAULT_CW = 4;

    localparam int MODE_RESET_DOM = 0;
    localparam int MODE_SET_DOM   = 1;
    localparam int MODE_HOLD      = 2;
    localparam int MODE_TOGGLE    = 3;

    typedef enum logic [1:0] {
        POLICY_RESET_DOM = 2'd0,
        POLICY_SET_DOM   = 2'd1,
        POLICY_HOLD      = 2'd2,
        POLICY_TOGGLE    = 2'd3
    } conflict_policy_e;

    // Next channel state for one enabled edge; the policy only matters when
    // set and reset are requested together.
    function automatic logic next_state(input conflict_policy_e policy,
                                        input logic q,
                                        input logic set,
                                        input logic reset);
        logic nxt;
        nxt = q;
        case ({set, reset})
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b11: begin
                case (policy)
                    POLICY_RESET_DOM: nxt = 1'b0;
                    POLICY_SET_DOM:   nxt = 1'b1;
                    POLICY_HOLD:      nxt = q;
                    POLICY_TOGGLE:    nxt = ~q;
                    default:          nxt = 1'b0;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One set/reset channel: registered state, rise pulse, saturating rise counter
// and an optional sticky conflict flag (SR_LATCH_BANK_CONFLICT_EN).
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter int MODE = MODE_RESET_DOM,
    parameter int CW   = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          set,
    input  logic          reset,
    input  logic          clr_cnt,
    output logic          q,
    output logic          rise,
    output logic [CW-1:0] cnt,
    output logic          conflict
);

    localparam conflict_policy_e POLICY  = conflict_policy_e'(MODE[1:0]);
    localparam logic [CW-1:0]    CNT_MAX = '1;

    logic q_next;
    logic rise_next;

    always_comb begin
        q_next    = next_state(POLICY, q, set, reset);
        rise_next = en & ~q & q_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= 1'b0;
            rise <= 1'b0;
        end else if (en) begin
            q    <= q_next;
            rise <= rise_next;
        end else begin
            rise <= 1'b0;
        end
    end

    // Clearing beats a same-edge increment; the counter sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt <= '0;
        end else if (rise_next && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef SR_LATCH_BANK_CONFLICT_EN
    logic conflict_r;

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            conflict_r <= 1'b0;
        end else if (en && set && reset) begin
            conflict_r <= 1'b1;
        end
    end

    assign conflict = conflict_r;
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N independent registered set/reset channels; replicates sr_cell and
// packs the per-channel outputs. Conflict flags need SR_LATCH_BANK_CONFLICT_EN.
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int MODE = MODE_RESET_DOM,
    parameter int CW   = DEFAULT_CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    set,
    input  logic [N-1:0]    reset,
    input  logic            clr_cnt,
    output logic [N-1:0]    q,
    output logic [N-1:0]    qbar,
    output logic [N-1:0]    rise,
    output logic [N*CW-1:0] cnt,
    output logic [N-1:0]    conflict
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_cell
            sr_cell #(
                .MODE (MODE),
                .CW   (CW)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .set      (set[i]),
                .reset    (reset[i]),
                .clr_cnt  (clr_cnt),
                .q        (q[i]),
                .rise     (rise[i]),
                .cnt      (cnt[i*CW +: CW]),
                .conflict (conflict[i])
            );
        end
    endgenerate

    assign qbar = ~q;

endmodule
